zsdram_port_arbiter: RTL
========================

# zsdram_port_arbiter

Three-requester arbiter sharing the single 4-word-burst SDRAM controller port between the LCD scan-out reader, the histogram shift/draw engine and the GRAM text/overlay engine. It sits between the requesters and the SDRAM controller. It uses the same level-request / single-cycle-done handshake on both sides, so each requester behaves as if it owned the controller. Port 0 has fixed top priority; ports 1 and 2 share the remaining bandwidth round-robin.

## Interface
Parameters:
- WDOG_CYCLES, 1024: cycles allowed in WAIT before timeout abort (only with ZARB_WATCHDOG_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- iRd_Req  in  3  per-port read request, level; bit N = port N.
- iWr_Req  in  3  per-port write request, level.
- iAddr  in  72  per-port 24-bit address (Bank2+Row13+Col9), 4-word aligned; port N = [24N+23:24N].
- iWr_Data  in  192  per-port 4x16 write words; port N = [64N+63:64N], Data1 in the low 16 bits.
- oRd_Done  out  3  one-cycle read-done pulse to the granted port.
- oWr_Done  out  3  one-cycle write-done pulse to the granted port.
- oRd_Data  out  64  last read burst (Data1..Data4, low to high), broadcast to all ports.
- oGrant  out  3  one-hot current owner; 0 when idle.
- oSDRAM_Rd_Req / oSDRAM_Wr_Req  out  1  level request to the controller.
- oSDRAM_Addr  out  24  latched address.
- oSDRAM_Wr_Data  out  64  latched write words.
- iSDRAM_Rd_Data  in  64  controller read words.
- iSDRAM_Rd_Done / iSDRAM_Wr_Done  in  1  controller done pulses.
- oTimeout  out  1  sticky watchdog flag.

## Operation
- States: IDLE, WAIT, HOLD.
- IDLE: form pending[N] = iRd_Req[N] | iWr_Req[N].
  - Port 0 wins if pending.
  - Otherwise the round-robin pointer rr selects between ports 1 and 2: the port equal to rr wins if pending, else the other port.
  - On a grant: latch oGrant, oSDRAM_Addr and oSDRAM_Wr_Data. Raise oSDRAM_Wr_Req if iWr_Req[N] is set, else raise oSDRAM_Rd_Req. Go to WAIT.
- Same port with both rd and wr asserted: the write is served first; the read is served on a later grant.
- rr update: after a grant to port 1, rr=2; after a grant to port 2, rr=1. A grant to port 0 leaves rr unchanged. Reset value rr=1.
- WAIT: hold all downstream outputs stable.
  - On the done matching the issued operation, drop the downstream request and pulse the corresponding oRd_Done/oWr_Done bit of the granted port.
  - For a read, capture iSDRAM_Rd_Data into oRd_Data at the same edge. Then go to HOLD.
  - A done of the wrong type, or any done received in IDLE/HOLD, is ignored.
- HOLD: one cycle with oGrant cleared, so the requester's dropped level is visible before the next arbitration. Then go to IDLE.
- Requesters must hold request, address and data stable until they see their done; they may change them afterwards.
- Reset, asynchronous, any state including mid-burst: return to IDLE with rr=1.
  - Outputs at reset: all requests, dones and oGrant = 0; oSDRAM_Addr = 0; oSDRAM_Wr_Data = 0; oRd_Data = 0; oTimeout = 0.
  - An in-flight controller transaction is abandoned; the controller shares rst_n.

## Timing
- Request high at edge k → oGrant and downstream request high after edge k (1-cycle grant latency).
- Controller done sampled at edge m → downstream request low and requester done high during cycle m+1. oRd_Data is valid from cycle m+1 and stays until the next read completes.
- HOLD occupies cycle m+2; the earliest next grant is after edge m+3. Controller request-off time is therefore ≥2 cycles.
- Port 0 continuously requesting starves ports 1 and 2. This is intended: LCD refresh is real-time.

## Configuration
- ZARB_WATCHDOG_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDOG_CYCLES-1 with no matching done: drop the downstream request, pulse the owner's done, leave oRd_Data unchanged, set oTimeout (cleared only by reset), and go to HOLD.
- ZARB_WATCHDOG_EN undefined: WAIT lasts indefinitely, no counter exists, and oTimeout is tied 0.

## Test plan
- Port 1 write, addr 384000, data 0x1111/2222/3333/4444, controller done 5 cycles after the request → oSDRAM_Wr_Req high for 6 cycles, matching addr/data downstream, one oWr_Done[1] pulse, oGrant=0 in HOLD.
- Ports 1 and 2 both reading continuously after reset → grants alternate 1,2,1,2; each oRd_Done pulse carries that port's iSDRAM_Rd_Data.
- Port 0 raises its read while port 2 is in WAIT → port 2 completes undisturbed, then port 0 is granted, then the port favoured by rr.
- Port 1 asserts rd and wr together, addr 7212 → write issued first, then the read on a later grant; exactly one oWr_Done[1] and one oRd_Done[1] pulse.
- rst_n low during WAIT of a read → all outputs 0 within the reset; after release, a pending port-2 request is granted normally.
- ZARB_WATCHDOG_EN with WDOG_CYCLES=16 and the controller never answering → oWr_Done pulses after 16 WAIT cycles and oTimeout stays 1.

Source files
------------

// File: rtl/zsdram_port_arbiter.sv
// Three-port arbiter in front of the 4-word-burst SDRAM controller: port 0 fixed priority, ports 1/2 round-robin.
// Optional watchdog abort of a stuck controller transaction is built when ZARB_WATCHDOG_EN is defined.
module zsdram_port_arbiter #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   iRd_Req,
  input  logic [2:0]   iWr_Req,
  input  logic [71:0]  iAddr,
  input  logic [191:0] iWr_Data,
  output logic [2:0]   oRd_Done,
  output logic [2:0]   oWr_Done,
  output logic [63:0]  oRd_Data,
  output logic [2:0]   oGrant,
  output logic         oSDRAM_Rd_Req,
  output logic         oSDRAM_Wr_Req,
  output logic [23:0]  oSDRAM_Addr,
  output logic [63:0]  oSDRAM_Wr_Data,
  input  logic [63:0]  iSDRAM_Rd_Data,
  input  logic         iSDRAM_Rd_Done,
  input  logic         iSDRAM_Wr_Done,
  output logic         oTimeout
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state;
  logic        rr_two;
  logic [2:0]  pending;
  logic [2:0]  sel;
  logic        sel_wr;
  logic [23:0] sel_addr;
  logic [63:0] sel_data;
  logic        busy;
  logic        match;
  logic        wdog_hit;
  logic        finish;

  always_comb begin
    pending = iRd_Req | iWr_Req;
    if (pending[0])  sel = 3'b001;
    else if (rr_two) sel = pending[2] ? 3'b100 : 3'b010;
    else             sel = pending[1] ? 3'b010 : 3'b100;
    sel_wr   = |(sel & iWr_Req);
    sel_addr = ({24{sel[0]}} & iAddr[23:0])    | ({24{sel[1]}} & iAddr[47:24])
             | ({24{sel[2]}} & iAddr[71:48]);
    sel_data = ({64{sel[0]}} & iWr_Data[63:0]) | ({64{sel[1]}} & iWr_Data[127:64])
             | ({64{sel[2]}} & iWr_Data[191:128]);
  end

  assign busy   = oSDRAM_Rd_Req | oSDRAM_Wr_Req;
  assign match  = (oSDRAM_Wr_Req & iSDRAM_Wr_Done) | (oSDRAM_Rd_Req & iSDRAM_Rd_Done);
  assign finish = (state == WAIT) && busy && (match || wdog_hit);

`ifdef ZARB_WATCHDOG_EN
  logic [15:0] wdog_cnt;

  assign wdog_hit = (wdog_cnt == 16'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      oTimeout <= 1'b0;
    end else begin
      if (state == IDLE)      wdog_cnt <= '0;
      else if (state == WAIT) wdog_cnt <= wdog_cnt + 16'd1;
      if (finish && !match)   oTimeout <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign oTimeout = 1'b0;
`endif

  // A completed WAIT keeps the grant for the done-pulse cycle, then HOLD clears it
  // so the requester's dropped level is seen before the next arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_two         <= 1'b0;
      oGrant         <= '0;
      oRd_Done       <= '0;
      oWr_Done       <= '0;
      oRd_Data       <= '0;
      oSDRAM_Rd_Req  <= 1'b0;
      oSDRAM_Wr_Req  <= 1'b0;
      oSDRAM_Addr    <= '0;
      oSDRAM_Wr_Data <= '0;
    end else begin
      oRd_Done <= '0;
      oWr_Done <= '0;
      case (state)
        IDLE: begin
          if (|pending) begin
            oGrant         <= sel;
            oSDRAM_Addr    <= sel_addr;
            oSDRAM_Wr_Data <= sel_data;
            oSDRAM_Wr_Req  <= sel_wr;
            oSDRAM_Rd_Req  <= !sel_wr;
            if (sel[1])      rr_two <= 1'b1;
            else if (sel[2]) rr_two <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!busy) begin
            oGrant <= '0;
            state  <= HOLD;
          end else if (finish) begin
            oSDRAM_Rd_Req <= 1'b0;
            oSDRAM_Wr_Req <= 1'b0;
            if (oSDRAM_Wr_Req) oWr_Done <= oGrant;
            else               oRd_Done <= oGrant;
            if (oSDRAM_Rd_Req && match) oRd_Data <= iSDRAM_Rd_Data;
          end
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
